// File: rtl/module_program_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package module_program_loader_pkg;

    // Loader sequencing: gather bytes, write a word, repeat, then signal completion.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // Number of stream bytes that make up one instruction word.
    function automatic int bytes_per_word(input int word_size);
        return word_size / 8;
    endfunction

endpackage

// File: rtl/module_program_loader_if.sv
// Byte stream in (valid/ready) plus the instruction-memory programming port out.
interface module_program_loader_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int WORD_SIZE    = 32
) ();
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    byte_ready;
    logic                    prog;
    logic [ADDRESS_BITS-1:0] addr;
    logic [WORD_SIZE-1:0]    code;

    // Loader side: consumes bytes, drives memory writes.
    modport slave  (input  byte_valid, byte_data,
                    output byte_ready, prog, addr, code);
    // Host/bench side: produces bytes, observes memory writes.
    modport master (output byte_valid, byte_data,
                    input  byte_ready, prog, addr, code);
endinterface

// File: rtl/module_program_loader.sv
// Packs a little-endian byte stream into words and writes them to instruction
// memory at consecutive addresses from 0, holding the CPU while loading.
module module_program_loader
    import module_program_loader_pkg::*;
#(
    parameter int ADDRESS_BITS = 32,
    parameter int WORD_SIZE    = 32,
    parameter int MEMORY       = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] len_words,
    module_program_loader_if.slave  lb,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int BPW   = bytes_per_word(WORD_SIZE);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    state_t                  state, state_nxt;
    logic [ADDRESS_BITS-1:0] len_q, word_idx, addr_q;
    logic [CNT_W-1:0]        byte_cnt;
    logic [WORD_SIZE-1:0]    pack, word_nxt, code_q;
    logic                    byte_ready_w, prog_w, accept, len_bad, last_word;

    assign len_bad   = len_words > ADDRESS_BITS'(MEMORY);
    assign accept    = lb.byte_valid && byte_ready_w;
    assign last_word = (word_idx + ADDRESS_BITS'(1)) == len_q;
    assign busy      = (state != IDLE);
    assign cpu_hold  = busy;

    assign lb.byte_ready = byte_ready_w;
    assign lb.prog       = prog_w;
    assign lb.addr       = addr_q;
    assign lb.code       = code_q;

    // Merge the incoming byte into its little-endian lane of the partial word.
    always_comb begin
        word_nxt = pack;
        word_nxt[{byte_cnt, 3'b000} +: 8] = lb.byte_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt    = state;
        byte_ready_w = 1'b0;
        prog_w       = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len_words == '0 || len_bad) ? FINISH : COLLECT;
            end
            COLLECT: begin
                byte_ready_w = 1'b1;
                if (lb.byte_valid && byte_cnt == LAST_BYTE) state_nxt = WRITE;
            end
            WRITE: begin
                prog_w    = 1'b1;
                state_nxt = last_word ? FINISH : COLLECT;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: length latch, byte packing, word counter, write port registers.
    // The word counter stops at len-1 so it never points past the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            pack     <= '0;
            addr_q   <= '0;
            code_q   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len_words;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        err      <= len_bad;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        pack <= word_nxt;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            addr_q   <= word_idx;
                            code_q   <= word_nxt;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (!last_word) word_idx <= word_idx + ADDRESS_BITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_program_loader.sv
// Scoreboard bench for the program loader: expected memory writes are queued
// by the stimulus and popped by a monitor whenever prog is seen.
module tb_module_program_loader;

    localparam int AB  = 32;
    localparam int WS  = 32;
    localparam int MEM = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] len_words = '0;
    logic          cpu_hold, busy, done, err;

    module_program_loader_if #(.ADDRESS_BITS(AB), .WORD_SIZE(WS)) bus ();

    module_program_loader #(.ADDRESS_BITS(AB), .WORD_SIZE(WS), .MEMORY(MEM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .lb        (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AB-1:0] a; logic [WS-1:0] d; } wr_t;
    wr_t         exp_q[$];
    logic [31:0] mem [0:MEM-1];
    int checks = 0, errors = 0;
    int prog_cnt = 0, done_cnt = 0, cyc = 0, last_done_cyc = 0, s_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] w4(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every write is matched against the scoreboard and stored in the memory model.
    always @(negedge clk) begin
        if (rst_n && bus.prog) begin
            wr_t e;
            prog_cnt++;
            chk("ready_low_in_write", {31'b0, bus.byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%h code=%h expected none", bus.addr, bus.code);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", bus.addr, e.a);
                chk("write_code", bus.code, e.d);
            end
            if (bus.addr < MEM) mem[bus.addr[3:0]] = bus.code;
        end
        if (rst_n && done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < MEM; i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    task automatic do_start(input logic [AB-1:0] len);
        start = 1'b1;
        len_words = len;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        int t = 0;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        if (pulse_start) begin
            start = 1'b1;
            len_words = 5;
        end
        do begin
            @(negedge clk);
            t++;
        end while (!bus.byte_ready && t < 200);
        if (!bus.byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout byte=%h ready=0 expected 1", b);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout_busy", {31'b0, busy}, 32'd0);
    endtask

    int p0, d0;
    int gaps [12] = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0, 4, 1};

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_prog", {31'b0, bus.prog}, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_code", bus.code, 0);
        chk("rst_busy_hold_done_err_ready", {27'b0, busy, cpu_hold, done, err, bus.byte_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three words back-to-back, then read the image back
        for (int w = 0; w < 3; w++) exp_q.push_back('{a: AB'(w), d: w4(4 * w)});
        p0 = prog_cnt; d0 = done_cnt;
        do_start(3);
        chk("t2_busy_hold", {30'b0, busy, cpu_hold}, 32'd3);
        for (int i = 0; i < 12; i++) drive_byte(8'(i), 0, 1'b0);
        wait_idle();
        chk("t2_prog_count", prog_cnt - p0, 3);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_latency", last_done_cyc - s_cyc, 15);
        chk("t2_mem0", mem[0], 32'h0302_0100);
        chk("t2_mem1", mem[1], 32'h0706_0504);
        chk("t2_mem2", mem[2], 32'h0B0A_0908);
        chk("t2_err", {31'b0, err}, 0);

        // Reset in the middle of a word: nothing written, outputs cleared
        p0 = prog_cnt;
        do_start(3);
        drive_byte(8'hF0, 0, 1'b0);
        drive_byte(8'hF1, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t1_addr", bus.addr, 0);
        chk("t1_code", bus.code, 0);
        chk("t1_busy_hold_done_prog_ready", {27'b0, busy, cpu_hold, done, bus.prog, bus.byte_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_no_write", prog_cnt - p0, 0);
        exp_q.push_back('{a: 0, d: 32'hA3A2_A1A0});
        do_start(1);
        for (int i = 0; i < 4; i++) drive_byte(8'hA0 + 8'(i), 0, 1'b0);
        wait_idle();
        chk("t1_reload_mem0", mem[0], 32'hA3A2_A1A0);

        // Zero-length load
        p0 = prog_cnt; d0 = done_cnt;
        do_start(0);
        chk("t3_done_next_cycle", {31'b0, done}, 1);
        @(posedge clk); #1;
        chk("t3_done_busy_after", {30'b0, done, busy}, 0);
        chk("t3_err", {31'b0, err}, 0);
        chk("t3_no_prog", prog_cnt - p0, 0);
        chk("t3_done_count", done_cnt - d0, 1);

        // Over-length load flags err, writes nothing; next start clears it
        p0 = prog_cnt;
        do_start(MEM + 1);
        chk("t4_err_done", {30'b0, err, done}, 32'd3);
        @(posedge clk); #1;
        chk("t4_err_sticky_idle", {30'b0, err, busy}, 32'd2);
        chk("t4_no_prog", prog_cnt - p0, 0);
        exp_q.push_back('{a: 0, d: 32'h4433_2211});
        do_start(1);
        chk("t4_err_cleared", {31'b0, err}, 0);
        for (int i = 0; i < 4; i++) drive_byte(8'h11 * 8'(i + 1), 0, 1'b0);
        wait_idle();
        chk("t4_one_write", prog_cnt - p0, 1);

        // Gappy stream plus a stray start mid-load
        clear_mem();
        for (int w = 0; w < 3; w++) exp_q.push_back('{a: AB'(w), d: w4(4 * w)});
        p0 = prog_cnt; d0 = done_cnt;
        do_start(3);
        for (int i = 0; i < 12; i++) drive_byte(8'(i), gaps[i], i == 6);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stays_idle", {31'b0, busy}, 0);
        chk("t5_prog_count", prog_cnt - p0, 3);
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_mem0", mem[0], 32'h0302_0100);
        chk("t5_mem1", mem[1], 32'h0706_0504);
        chk("t5_mem2", mem[2], 32'h0B0A_0908);
        chk("t5_mem3_untouched", mem[3], 32'hDEAD_BEEF);

        // Full-depth load: last write at MEM-1, hold drops two cycles after it
        for (int w = 0; w < MEM; w++) exp_q.push_back('{a: AB'(w), d: w4(4 * w)});
        do_start(MEM);
        for (int i = 0; i < 4 * MEM; i++) drive_byte(8'(i), 0, 1'b0);
        chk("t6_final_prog", {31'b0, bus.prog}, 1);
        chk("t6_final_addr", bus.addr, MEM - 1);
        @(posedge clk); #1;
        chk("t6_hold_done_prog", {29'b0, cpu_hold, done, bus.prog}, 32'd6);
        @(posedge clk); #1;
        chk("t6_hold_busy_low", {30'b0, cpu_hold, busy}, 0);
        chk("t6_addr_no_wrap", bus.addr, MEM - 1);
        chk("t6_mem_last", mem[MEM-1], w4(4 * (MEM - 1)));

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout reached=1 expected 0");
        $fatal(1, "watchdog");
    end

endmodule
